// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider scheduler and divider blocks.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int MIN_RATIO = 2;

    // First toggle point of a divided period: (r-1)>>1.
    function automatic logic [31:0] half_point(input logic [31:0] r);
        return (r - 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_sched_rr_arbiter.sv
// Round-robin arbiter: the lowest requester at or after the pointer wins.
// The pointer moves to winner+1 only when update is asserted.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] grant
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        int idx;
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Explicit wrap keeps the pointer legal when N is not a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update && found) begin
            if (int'(win) == N - 1) ptr <= '0;
            else                    ptr <= win + PW'(1);
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Divide-ratio scheduler: arbitrates ratio requests and applies them only at
// a divided-period boundary while running the divider's phase counter.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int W             = 8,
    parameter int DEFAULT_RATIO = 5
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_ratio,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      cur_ratio,
    output logic [W-1:0]      cnt,
    output logic              half_tick,
    output logic              period_tick,
    output logic              busy,
    output logic              switch_done,
    output logic              err
);

    state_t          state;
    state_t          state_nxt;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    win_ratio;
    logic [W-1:0]    pend_ratio;
    logic            transfer;
    logic            ratio_ok;
    logic            apply;
    logic            sd_q;
    logic            err_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk    (clk_in),
        .rst    (rst),
        .req    (req_valid),
        .update (transfer),
        .grant  (grant)
    );

    always_comb begin
        win_ratio = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_ratio = req_ratio[i*W +: W];
        end
    end

    assign ratio_ok    = (win_ratio >= W'(MIN_RATIO));
    assign half_tick   = (cnt == W'(half_point(32'(cur_ratio))));
    assign period_tick = (cnt == cur_ratio - W'(1));
    assign transfer    = |req_ready;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req_ready = grant;
                    if (|grant && ratio_ok) begin
                        busy      = 1'b1;
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                busy = !rst;
                if (period_tick) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ratio swaps only on the wrap, so the old period always completes.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_ratio <= W'(DEFAULT_RATIO);
            sd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            sd_q  <= apply;
            err_q <= transfer && !ratio_ok;
            if (apply) begin
                cnt       <= '0;
                cur_ratio <= pend_ratio;
            end else if (period_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (transfer) pend_ratio <= win_ratio;
    end

    assign switch_done = sd_q && !rst;
    assign err         = err_q && !rst;

endmodule
